// File: rtl/seg_disp_pkg.sv
// Shared definitions for the seven-segment display arbiter: FSM state
// encoding and the source-index width helper.
package seg_disp_pkg;

   // Arbiter FSM states: waiting for a requester, or holding a grant on screen.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DWELL = 1'b1
   } state_t;

   // Width of a source index. Clamped to at least one bit so a
   // degenerate single-source build still has a legal vector.
   function automatic int src_w(input int num_src);
      return (num_src > 1) ? $clog2(num_src) : 1;
   endfunction

endpackage

// File: rtl/seg_disp_arbiter_rr_pick.sv
// Combinational round-robin picker: starting just after the previous
// winner and wrapping around, returns the first requesting source.
module rr_pick
   import seg_disp_pkg::*;
#(
   parameter  int NUM_SRC = 4,
   localparam int SRC_W   = src_w(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   last_grant,
   output logic [SRC_W-1:0]   winner,
   output logic               any
);

   // Scan (last_grant+1) .. (last_grant+NUM_SRC) mod NUM_SRC; the first set bit wins.
   always_comb begin : p_pick
      int  idx;
      logic found;
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      winner = '0;
      any    = |req;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         idx = (int'(last_grant) + k) % NUM_SRC;
         if (!found && req[idx]) begin
            winner = SRC_W'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display between
// NUM_SRC requesters. Each winner is latched and held for DWELL_CYCLES so
// a human can read it; lock freezes the display and pauses the dwell.
module seg_disp_arbiter
   import seg_disp_pkg::*;
#(
   parameter  int NUM_SRC      = 4,
   parameter  int DATA_W       = 12,
   parameter  int DWELL_CYCLES = 100_000_000,
   localparam int SRC_W        = src_w(NUM_SRC),
   localparam int CNT_W        = $clog2(DWELL_CYCLES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        req,
   input  logic [NUM_SRC*DATA_W-1:0] data,
   input  logic                      lock,
   output logic [DATA_W-1:0]         disp_addr,
   output logic [SRC_W-1:0]          disp_src,
   output logic                      disp_valid,
   output logic [NUM_SRC-1:0]        ack
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_dwell_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [SRC_W-1:0]    r_last_grant;
   logic [DATA_W-1:0]   r_disp_addr;
   logic [SRC_W-1:0]    r_disp_src;
   logic                r_disp_valid;
   logic [NUM_SRC-1:0]  r_ack;

   logic [SRC_W-1:0]    w_winner;
   logic                w_any;
   logic                w_grant;
   logic                w_terminal;
   logic [DATA_W-1:0]   w_sel_data;

   rr_pick #(
      .NUM_SRC (NUM_SRC)
   ) u_rr_pick (
      .req        (req),
      .last_grant (r_last_grant),
      .winner     (w_winner),
      .any        (w_any)
   );

   assign w_terminal = (r_dwell_cnt == CNT_W'(DWELL_CYCLES - 1));
   assign w_sel_data = data[int'(w_winner)*DATA_W +: DATA_W];

   // State register and dwell counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state     <= ST_IDLE;
         r_dwell_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_dwell_cnt <= w_cnt_nxt;
      end
   end

   // Next-state, counter update and grant decision; lock freezes everything.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_dwell_cnt;
      w_grant     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!lock && w_any) begin
               w_grant     = 1'b1;
               w_state_nxt = ST_DWELL;
               w_cnt_nxt   = '0;
            end
         end
         ST_DWELL: begin
            if (!lock) begin
               if (w_terminal) begin
                  w_cnt_nxt = '0;
                  if (w_any) begin
                     w_grant = 1'b1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_cnt_nxt = r_dwell_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Display registers: capture winner data/index on the grant edge, pulse ack for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_disp_addr  <= '0;
         r_disp_src   <= '0;
         r_disp_valid <= 1'b0;
         r_ack        <= '0;
         r_last_grant <= SRC_W'(NUM_SRC - 1);
      end else begin
         r_ack <= '0;
         if (w_grant) begin
            r_disp_addr            <= w_sel_data;
            r_disp_src             <= w_winner;
            r_last_grant           <= w_winner;
            r_disp_valid           <= 1'b1;
            r_ack[w_winner]        <= 1'b1;
         end
      end
   end

   assign disp_addr  = r_disp_addr;
   assign disp_src   = r_disp_src;
   assign disp_valid = r_disp_valid;
   assign ack        = r_ack;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Self-checking bench for seg_disp_arbiter: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_seg_disp_arbiter;

   localparam int NUM_SRC = 4;
   localparam int DATA_W  = 12;
   localparam int DWELL   = 8;
   localparam int SRC_W   = 2;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      lock;
   logic [NUM_SRC-1:0]        req;
   logic [NUM_SRC*DATA_W-1:0] data;
   logic [DATA_W-1:0]         disp_addr;
   logic [SRC_W-1:0]          disp_src;
   logic                      disp_valid;
   logic [NUM_SRC-1:0]        ack;

   always #5 clk = ~clk;

   seg_disp_arbiter #(
      .NUM_SRC      (NUM_SRC),
      .DATA_W       (DATA_W),
      .DWELL_CYCLES (DWELL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .data       (data),
      .lock       (lock),
      .disp_addr  (disp_addr),
      .disp_src   (disp_src),
      .disp_valid (disp_valid),
      .ack        (ack)
   );

   int n_total = 0;
   int n_pass  = 0;

   // Single comparison point: counts and reports mismatches.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Behavioural model: a grant is shown for DWELL unlocked cycles, then the
   // next requester after the previous winner (wrapping) takes over.
   int          m_last    = NUM_SRC - 1;
   bit          m_showing = 0;   // a grant is currently being held on screen
   int          m_elapsed = 0;   // unlocked cycles since that grant
   int          m_addr    = 0;
   int          m_src     = 0;
   bit          m_valid   = 0;
   int          m_ack     = 0;

   function automatic int next_winner(input logic [NUM_SRC-1:0] r, input int last);
      for (int k = 1; k <= NUM_SRC; k++) begin
         if (r[(last + k) % NUM_SRC]) return (last + k) % NUM_SRC;
      end
      return -1;
   endfunction

   task automatic model_edge();
      int w;
      m_ack = 0;
      if (rst) begin
         m_last = NUM_SRC - 1; m_showing = 0; m_elapsed = 0;
         m_addr = 0; m_src = 0; m_valid = 0;
      end else if (!lock) begin
         if (!m_showing || m_elapsed == DWELL - 1) begin
            w = next_winner(req, m_last);
            if (w >= 0) begin
               m_addr    = int'(data[w*DATA_W +: DATA_W]);
               m_src     = w;
               m_last    = w;
               m_valid   = 1;
               m_ack     = 1 << w;
               m_showing = 1;
            end else begin
               m_showing = 0;
            end
            m_elapsed = 0;
         end else begin
            m_elapsed++;
         end
      end
   endtask

   // One clock: inputs already stable, model follows the edge, outputs sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("disp_addr",  disp_addr,  m_addr);
      check("disp_src",   disp_src,   m_src);
      check("disp_valid", disp_valid, m_valid);
      check("ack",        ack,        m_ack);
   endtask

   task automatic set_src(input int i, input int v);
      data[i*DATA_W +: DATA_W] = DATA_W'(v);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; lock = 1'b0;
      step();
      rst = 1'b0;
   endtask

   int t_grant0, seen, k;
   int rr_vals[5] = '{11, 22, 33, 44, 11};

   initial begin
      rst = 1'b1; req = '0; lock = 1'b0; data = '0;
      #2;

      // 1. Reset and quiet idle.
      step(); step();
      check("rst_valid", disp_valid, 0);
      check("rst_ack", ack, 0);
      rst = 1'b0;
      repeat (3) step();
      check("idle_valid", disp_valid, 0);

      // 2. Single grant of source 2.
      set_src(2, 1234); req = 4'b0100;
      step();
      check("t2_addr", disp_addr, 1234);
      check("t2_src", disp_src, 2);
      check("t2_ack", ack, 4'b0100);
      req = '0;
      step();
      check("t2_ack_drop", ack, 0);
      repeat (10) step();

      // 3. Round-robin over four requesters, grants 8 cycles apart.
      do_reset();
      set_src(0, 11); set_src(1, 22); set_src(2, 33); set_src(3, 44);
      req = 4'b1111;
      seen = 0; t_grant0 = -1;
      for (int c = 0; c < 40 && seen < 5; c++) begin
         step();
         if (ack != 0) begin
            check("t3_val", disp_addr, rr_vals[seen]);
            check("t3_onehot", $onehot(ack), 1);
            if (t_grant0 >= 0) check("t3_gap", c - t_grant0, DWELL);
            t_grant0 = c;
            seen++;
         end
      end
      check("t3_count", seen, 5);

      // 4. Drop request, return to idle, then a fresh grant of source 3.
      do_reset();
      set_src(1, 777); set_src(3, 999);
      req = 4'b0010;
      step();
      req = '0;
      repeat (DWELL) step();
      check("t4_hold", disp_addr, 777);
      step();
      check("t4_idle_ack", ack, 0);
      req = 4'b1000;
      step();
      check("t4_src", disp_src, 3);
      check("t4_ack", ack, 4'b1000);

      // 5. Lock during source 0 dwell stretches the hand-over to 13 cycles.
      do_reset();
      req = 4'b0001;
      step();
      req = 4'b0011;
      k = 0;
      repeat (2) begin step(); k++; end
      lock = 1'b1;
      repeat (5) begin step(); k++; check("t5_lock_ack", ack, 0); end
      lock = 1'b0;
      seen = 0;
      for (int c = 0; c < 30 && seen == 0; c++) begin
         step(); k++;
         if (ack != 0) seen = 1;
      end
      check("t5_seen", seen, 1);
      check("t5_latency", k, 13);
      check("t5_src", disp_src, 1);

      // 6. Reset mid-dwell, then source 0 wins first.
      do_reset();
      req = 4'b0100;
      step();
      repeat (4) step();
      rst = 1'b1; req = 4'b0101;
      step();
      check("t6_rst_valid", disp_valid, 0);
      check("t6_rst_ack", ack, 0);
      rst = 1'b0;
      step();
      check("t6_src", disp_src, 0);

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         req  = NUM_SRC'($urandom);
         if ($urandom_range(0, 3) == 0) req = '0;
         lock = ($urandom_range(0, 9) == 0);
         rst  = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 2) == 0) data = {$urandom, $urandom};
         step();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
